// File: rtl/collision_pkg.sv
// Shared types and widths for the collision event scheduler and its frame accumulators.
package collision_pkg;
  localparam int LIVES_W     = 3;
  localparam int FRAME_CNT_W = 8;

  typedef enum logic [1:0] {ALIVE, HIT_FREEZE, INVULN, GAME_OVER} life_state_t;

  typedef struct packed {
    logic player;
    logic rope;
    logic present;
  } col_snapshot_t;
endpackage

// File: rtl/col_frame_accumulator.sv
// Per-input frame accumulator: a sticky flag (or, with COL_PIXEL_THRESH_EN, a saturating
// pixel counter) that is snapshotted and restarted on every startOfFrame.
module col_frame_accumulator
  import collision_pkg::*;
#(
  parameter int PIXEL_THRESH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic sof,
  input  logic col_in,
  output logic hit
);

  if (PIXEL_THRESH < 1 || PIXEL_THRESH > 255) begin : g_bad_thresh
    $error("PIXEL_THRESH must be in 1..255");
  end

`ifdef COL_PIXEL_THRESH_EN
  logic [FRAME_CNT_W-1:0] cnt_q, cnt_d;

  // The startOfFrame cycle's own pixel already counts toward the new frame.
  always_comb begin
    cnt_d = cnt_q;
    if (sof) begin
      cnt_d = {{(FRAME_CNT_W-1){1'b0}}, col_in};
    end else if (col_in && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign hit = (int'(cnt_q) >= PIXEL_THRESH);
`else
  logic flag_q, flag_d;

  always_comb begin
    flag_d = flag_q | col_in;
    if (sof) flag_d = col_in;
  end

  always_ff @(posedge clk) begin
    if (reset) flag_q <= 1'b0;
    else       flag_q <= flag_d;
  end

  assign hit = flag_q;
`endif

endmodule

// File: rtl/collision_event_scheduler.sv
// Frame-based collision evaluation, game-event pulses and the player life/freeze/invuln FSM.
// Optional macro COL_PIXEL_THRESH_EN switches the accumulators to pixel-count thresholds.
module collision_event_scheduler
  import collision_pkg::*;
#(
  parameter int INIT_LIVES    = 3,
  parameter int FREEZE_FRAMES = 60,
  parameter int INVULN_FRAMES = 120,
  parameter int PIXEL_THRESH  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic               col_player_ball,
  input  logic               col_rope_ball,
  input  logic               col_present,
  output logic               player_hit_pulse,
  output logic               ball_pop_pulse,
  output logic               rope_clear_pulse,
  output logic               present_pulse,
  output logic               freeze_game,
  output logic               invulnerable,
  output logic [LIVES_W-1:0] lives,
  output logic               game_over
);

  if (FREEZE_FRAMES < 1 || FREEZE_FRAMES > 255 || INVULN_FRAMES < 1 || INVULN_FRAMES > 255)
  begin : g_bad_frames
    $error("FREEZE_FRAMES and INVULN_FRAMES must be in 1..255");
  end
  if (INIT_LIVES < 1 || INIT_LIVES > 7) begin : g_bad_lives
    $error("INIT_LIVES must be in 1..7");
  end

  localparam int CNT_MAX_I = (FREEZE_FRAMES > INVULN_FRAMES) ? FREEZE_FRAMES : INVULN_FRAMES;
  localparam logic [FRAME_CNT_W-1:0] CNT_MAX     = FRAME_CNT_W'(CNT_MAX_I);
  localparam logic [FRAME_CNT_W-1:0] FREEZE_LAST = FRAME_CNT_W'(FREEZE_FRAMES - 1);
  localparam logic [FRAME_CNT_W-1:0] INVULN_LAST = FRAME_CNT_W'(INVULN_FRAMES - 1);
  localparam logic [LIVES_W-1:0]     LIVES_INIT  = LIVES_W'(INIT_LIVES);

  logic snap_player, snap_rope, snap_present;
  col_snapshot_t snap;

  col_frame_accumulator #(.PIXEL_THRESH(PIXEL_THRESH)) u_acc_player (
    .clk(clk), .reset(reset), .sof(startOfFrame), .col_in(col_player_ball), .hit(snap_player)
  );
  col_frame_accumulator #(.PIXEL_THRESH(PIXEL_THRESH)) u_acc_rope (
    .clk(clk), .reset(reset), .sof(startOfFrame), .col_in(col_rope_ball), .hit(snap_rope)
  );
  col_frame_accumulator #(.PIXEL_THRESH(PIXEL_THRESH)) u_acc_present (
    .clk(clk), .reset(reset), .sof(startOfFrame), .col_in(col_present), .hit(snap_present)
  );

  assign snap = '{player: snap_player, rope: snap_rope, present: snap_present};

  life_state_t            state_q, state_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [LIVES_W-1:0]     lives_q, lives_d;
  logic                   player_hit_q, player_hit_d;
  logic                   ball_pop_q, ball_pop_d;
  logic                   present_q, present_d;

  always_comb begin
    state_d      = state_q;
    frame_cnt_d  = frame_cnt_q;
    lives_d      = lives_q;
    player_hit_d = 1'b0;
    ball_pop_d   = 1'b0;
    present_d    = 1'b0;

    // Snapshot evaluation always uses the state held before this edge's transition.
    if (startOfFrame) begin
      unique case (state_q)
        ALIVE: begin
          if (snap.player) begin
            // A hit still pending from the previous cycle must not cost a second life.
            player_hit_d = !player_hit_q;
          end else begin
            ball_pop_d = snap.rope;
            present_d  = snap.present;
          end
        end
        INVULN: begin
          ball_pop_d = snap.rope;
          present_d  = snap.present;
        end
        default: ;
      endcase
    end

    unique case (state_q)
      ALIVE: begin
        if (player_hit_q) begin
          lives_d     = (lives_q != '0) ? lives_q - 1'b1 : '0;
          state_d     = (lives_q <= LIVES_W'(1)) ? GAME_OVER : HIT_FREEZE;
          frame_cnt_d = '0;
        end
      end
      HIT_FREEZE: begin
        if (startOfFrame) begin
          if (frame_cnt_q >= FREEZE_LAST) begin
            state_d     = INVULN;
            frame_cnt_d = '0;
          end else begin
            frame_cnt_d = (frame_cnt_q == CNT_MAX) ? frame_cnt_q : frame_cnt_q + 1'b1;
          end
        end
      end
      INVULN: begin
        if (startOfFrame) begin
          if (frame_cnt_q >= INVULN_LAST) begin
            state_d     = ALIVE;
            frame_cnt_d = '0;
          end else begin
            frame_cnt_d = (frame_cnt_q == CNT_MAX) ? frame_cnt_q : frame_cnt_q + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ALIVE;
      frame_cnt_q  <= '0;
      lives_q      <= LIVES_INIT;
      player_hit_q <= 1'b0;
      ball_pop_q   <= 1'b0;
      present_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_cnt_q  <= frame_cnt_d;
      lives_q      <= lives_d;
      player_hit_q <= player_hit_d;
      ball_pop_q   <= ball_pop_d;
      present_q    <= present_d;
    end
  end

  assign player_hit_pulse = player_hit_q;
  assign ball_pop_pulse   = ball_pop_q;
  assign rope_clear_pulse = ball_pop_q;
  assign present_pulse    = present_q;
  assign freeze_game      = (state_q == HIT_FREEZE) || (state_q == GAME_OVER);
  assign invulnerable     = (state_q == INVULN);
  assign game_over        = (state_q == GAME_OVER);
  assign lives            = lives_q;

endmodule

// File: tb/tb_collision_event_scheduler.sv
// Directed bench for collision_event_scheduler: a 3-life and a 1-life instance share stimulus.
module tb_collision_event_scheduler;

  logic clk = 1'b0;
  logic reset, sof, cp, cr, cpr;

  logic ph, bp, rc, pp, frz, inv, go;
  logic [2:0] lv;
  logic ph1, bp1, rc1, pp1, frz1, inv1, go1;
  logic [2:0] lv1;

  logic [3:0] pulses, pulses1;
  assign pulses  = {ph, bp, rc, pp};
  assign pulses1 = {ph1, bp1, rc1, pp1};

  int n_tests = 0;
  int n_fail  = 0;
  int npix;

  always #5 clk = ~clk;

  collision_event_scheduler #(
    .INIT_LIVES(3), .FREEZE_FRAMES(2), .INVULN_FRAMES(3), .PIXEL_THRESH(4)
  ) dut (
    .clk(clk), .reset(reset), .startOfFrame(sof),
    .col_player_ball(cp), .col_rope_ball(cr), .col_present(cpr),
    .player_hit_pulse(ph), .ball_pop_pulse(bp), .rope_clear_pulse(rc), .present_pulse(pp),
    .freeze_game(frz), .invulnerable(inv), .lives(lv), .game_over(go)
  );

  collision_event_scheduler #(
    .INIT_LIVES(1), .FREEZE_FRAMES(2), .INVULN_FRAMES(3), .PIXEL_THRESH(4)
  ) dut1 (
    .clk(clk), .reset(reset), .startOfFrame(sof),
    .col_player_ball(cp), .col_rope_ball(cr), .col_present(cpr),
    .player_hit_pulse(ph1), .ball_pop_pulse(bp1), .rope_clear_pulse(rc1), .present_pulse(pp1),
    .freeze_game(frz1), .invulnerable(inv1), .lives(lv1), .game_over(go1)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold the given collisions for npix cycles mid-frame, then one quiet cycle.
  task automatic hit(input logic p, input logic r, input logic pr);
    cp = p; cr = r; cpr = pr;
    repeat (npix) step();
    cp = 0; cr = 0; cpr = 0;
    step();
  endtask

  // Pulse order in the vectors: {player_hit, ball_pop, rope_clear, present}.
  task automatic eval_frame(input string tag, input logic [3:0] exp, input logic [3:0] exp1);
    sof = 1;
    step();
    check({tag, "_pulses"}, 32'(pulses), 32'(exp));
    check({tag, "_pulses1"}, 32'(pulses1), 32'(exp1));
    sof = 0;
    step();
    check({tag, "_onecycle"}, 32'(pulses | pulses1), 32'd0);
  endtask

  initial begin
`ifdef COL_PIXEL_THRESH_EN
    npix = 4;
`else
    npix = 1;
`endif
    reset = 1; sof = 0; cp = 0; cr = 0; cpr = 0;
    step();
    step();
    check("rst_pulses", 32'(pulses), 32'd0);
    check("rst_lives", 32'(lv), 32'd3);
    check("rst_flags", 32'({frz, inv, go}), 32'd0);
    check("rst_lives1", 32'(lv1), 32'd1);
    reset = 0;
    step();

    // Rope pop in ALIVE.
    hit(0, 1, 0);
    eval_frame("pop", 4'b0110, 4'b0110);
    check("pop_lives", 32'(lv), 32'd3);

    // Player hit masks the simultaneous rope and present.
    hit(1, 1, 1);
    eval_frame("hit", 4'b1000, 4'b1000);
    check("hit_lives", 32'(lv), 32'd2);
    check("hit_freeze", 32'(frz), 32'd1);
    check("hit_inv", 32'(inv), 32'd0);
    check("go_lives1", 32'(lv1), 32'd0);
    check("go_flags1", 32'({go1, frz1}), 32'b11);

    // Two frozen frames, then three invulnerable frames, then vulnerable again.
    hit(1, 1, 1);
    eval_frame("frz_a", 4'b0000, 4'b0000);
    hit(1, 1, 1);
    eval_frame("frz_b", 4'b0000, 4'b0000);
    check("inv_on", 32'({inv, frz}), 32'b10);
    for (int i = 0; i < 3; i++) begin
      hit(1, 1, 0);
      eval_frame($sformatf("inv_%0d", i), 4'b0110, 4'b0000);
    end
    check("inv_off", 32'({inv, frz}), 32'b00);
    hit(1, 0, 0);
    eval_frame("hit2", 4'b1000, 4'b0000);
    check("hit2_lives", 32'(lv), 32'd1);
    check("hit2_freeze", 32'(frz), 32'd1);
    check("go_sticky1", 32'({go1, lv1}), 32'({1'b1, 3'd0}));

    // Reset leaves GAME_OVER and restores lives.
    reset = 1;
    step();
    reset = 0;
    check("rst2_go1", 32'({go1, frz1, lv1}), 32'({2'b00, 3'd1}));
    check("rst2_lives", 32'(lv), 32'd3);

    // Collision raised on the startOfFrame cycle belongs to the next frame.
    sof = 1; cr = 1;
    step();
    check("sofcol_none", 32'(pulses | pulses1), 32'd0);
    sof = 0;
    cr = (npix > 1);
    repeat (npix - 1) step();
    cr = 0;
    step();
    eval_frame("sofcol_next", 4'b0110, 4'b0110);

    hit(0, 1, 1);
    eval_frame("pop_pres", 4'b0111, 4'b0111);
    hit(0, 0, 1);
    eval_frame("pres", 4'b0001, 4'b0001);
    eval_frame("empty", 4'b0000, 4'b0000);

`ifdef COL_PIXEL_THRESH_EN
    cr = 1;
    repeat (3) step();
    cr = 0;
    step();
    eval_frame("thr3", 4'b0000, 4'b0000);
    cr = 1;
    repeat (4) step();
    cr = 0;
    step();
    eval_frame("thr4", 4'b0110, 4'b0110);
    cr = 1;
    repeat (3) step();
    cr = 0; reset = 1;
    step();
    reset = 0;
    step();
    eval_frame("thr_rst", 4'b0000, 4'b0000);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
